qmac_accum: RTL and testbench

Sequential dot-product accumulator that sits directly downstream of the 8x8 approximate multiplier. Each cycle it consumes one product pair (exact and approximate) through a valid/ready handshake. After LEN accepted terms it presents both dot-product sums and their difference, which lets the bench compare approximate-MAC error against the exact reference over realistic vector lengths. The output is held under backpressure, and then the block clears itself for the next dot product.

---
 rtl/qmac_accum.sv | 129 ++++++++++++
 tb/tb_qmac_accum.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmac_accum.sv
// qmac_accum: LEN-term dot-product accumulator for exact/approximate product pairs.
// Define QMAC_SAT_EN to clamp each accumulator add to the signed ACC_W range.
module qmac_accum #(
   parameter int LEN   = 16,
   parameter int ACC_W = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [15:0]      in_exact,
   input  logic signed [15:0]      in_approx,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_acc_exact,
   output logic signed [ACC_W-1:0] out_acc_approx,
   output logic signed [ACC_W-1:0] out_err,
   output logic                    out_sat
);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

   localparam logic [15:0] LAST_CNT = 16'(LEN - 1);

   state_e                  state_q, state_d;
   logic [15:0]             cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_exact_q, acc_exact_d;
   logic signed [ACC_W-1:0] acc_approx_q, acc_approx_d;
   logic signed [ACC_W-1:0] err_q, err_d;
   logic                    sat_q, sat_d;
   logic [ACC_W:0]          add_exact_s, add_approx_s;

   // Returns {clamped, sum}: term is sign-extended to ACC_W before the add.
   function automatic logic [ACC_W:0] add_term(input logic [ACC_W-1:0] acc,
                                                input logic [15:0]      term);
      logic [ACC_W-1:0] sum;
      logic             clamped;
`ifdef QMAC_SAT_EN
      logic [ACC_W:0]   wide;
      wide = {acc[ACC_W-1], acc} + {{(ACC_W-15){term[15]}}, term};
      if (wide[ACC_W] != wide[ACC_W-1]) begin
         clamped = 1'b1;
         sum     = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         clamped = 1'b0;
         sum     = wide[ACC_W-1:0];
      end
`else
      clamped = 1'b0;
      sum     = acc + {{(ACC_W-16){term[15]}}, term};
`endif
      return {clamped, sum};
   endfunction

   // Next-state: accumulate beats in ACCUM, present and clear the result in HOLD.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_exact_d  = acc_exact_q;
      acc_approx_d = acc_approx_q;
      err_d        = err_q;
      sat_d        = sat_q;
      add_exact_s  = add_term(acc_exact_q, in_exact);
      add_approx_s = add_term(acc_approx_q, in_approx);
      case (state_q)
         ST_ACCUM: begin
            if (in_valid) begin
               acc_exact_d  = add_exact_s[ACC_W-1:0];
               acc_approx_d = add_approx_s[ACC_W-1:0];
               sat_d        = sat_q | add_exact_s[ACC_W] | add_approx_s[ACC_W];
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = 16'd0;
                  err_d   = add_exact_s[ACC_W-1:0] - add_approx_s[ACC_W-1:0];
                  state_d = ST_HOLD;
               end else begin
                  cnt_d   = cnt_q + 16'd1;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               acc_exact_d  = '0;
               acc_approx_d = '0;
               err_d        = '0;
               sat_d        = 1'b0;
               state_d      = ST_ACCUM;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_ACCUM;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial or held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ACCUM;
         cnt_q        <= 16'd0;
         acc_exact_q  <= '0;
         acc_approx_q <= '0;
         err_q        <= '0;
         sat_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_exact_q  <= acc_exact_d;
         acc_approx_q <= acc_approx_d;
         err_q        <= err_d;
         sat_q        <= sat_d;
      end
   end

   assign in_ready       = (state_q == ST_ACCUM);
   assign out_valid      = (state_q == ST_HOLD);
   assign out_acc_exact  = acc_exact_q;
   assign out_acc_approx = acc_approx_q;
   assign out_err        = err_q;
   assign out_sat        = sat_q;

endmodule

// File: tb/tb_qmac_accum.sv
// Bench for qmac_accum: three instances (LEN=4/ACC_W=24, LEN=4/ACC_W=17, LEN=1/ACC_W=24)
// share one stimulus stream; each is checked every cycle against a term-sum model.
`timescale 1ns/1ps
module tb_qmac_accum;
   localparam int NDUT = 3;

   function automatic int len_of(input int k);
      case (k)
         2: return 1;
         default: return 4;
      endcase
   endfunction

   function automatic int aw_of(input int k);
      case (k)
         1: return 17;
         default: return 24;
      endcase
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1;
   logic              in_valid = 1'b1;
   logic              out_ready = 1'b0;
   logic signed [15:0] in_exact = 16'sd55;
   logic signed [15:0] in_approx = 16'sd44;

   logic              rdy [NDUT];
   logic              vld [NDUT];
   logic              sat [NDUT];
   logic signed [31:0] acc_e [NDUT];
   logic signed [31:0] acc_a [NDUT];
   logic signed [31:0] err [NDUT];

   int n_chk = 0;
   int n_err = 0;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int L  = len_of(g);
      localparam int AW = aw_of(g);
      logic signed [AW-1:0] ae, aa, er;
      logic r, v, s;
      qmac_accum #(.LEN(L), .ACC_W(AW)) u_dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r),
         .in_exact(in_exact), .in_approx(in_approx), .out_valid(v),
         .out_ready(out_ready), .out_acc_exact(ae), .out_acc_approx(aa),
         .out_err(er), .out_sat(s));
      assign rdy[g]   = r;
      assign vld[g]   = v;
      assign sat[g]   = s;
      assign acc_e[g] = 32'(ae);
      assign acc_a[g] = 32'(aa);
      assign err[g]   = 32'(er);
   end

   task automatic chk(input string nm, input int k, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s[dut%0d] at %0t: got=%0d exp=%0d", nm, k, $time, got, exp);
      end
   endtask

   // Inputs as the DUTs sampled them on the last rising edge.
   logic s_rst = 1'b1, s_valid = 1'b0, s_ordy = 1'b0;
   int   s_e = 0, s_a = 0;
   always @(posedge clk) begin
      s_rst   <= rst;
      s_valid <= in_valid;
      s_ordy  <= out_ready;
      s_e     <= int'(in_exact);
      s_a     <= int'(in_approx);
   end

   // Model: unbounded running sums (clamped per term when saturating), wrapped on read.
   bit     m_hold [NDUT];
   bit     m_sat  [NDUT];
   int     m_cnt  [NDUT];
   longint m_se   [NDUT];
   longint m_sa   [NDUT];
   longint m_err  [NDUT];

   function automatic longint wrapw(input longint v, input int aw);
      longint m, r;
      m = longint'(1) <<< aw;
      r = v % m;
      if (r < 0) r = r + m;
      if (r >= (m >>> 1)) r = r - m;
      return r;
   endfunction

`ifdef QMAC_SAT_EN
   function automatic longint clampw(input longint v, input int aw, output bit hit);
      longint hi, lo;
      hi  = (longint'(1) <<< (aw - 1)) - 1;
      lo  = -hi - 1;
      hit = (v > hi) || (v < lo);
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction
`endif

   task automatic model_clear(input int k);
      m_hold[k] = 1'b0; m_sat[k] = 1'b0; m_cnt[k] = 0;
      m_se[k] = 0; m_sa[k] = 0; m_err[k] = 0;
   endtask

   task automatic model_step(input int k);
      int aw;
      aw = aw_of(k);
      if (s_rst) begin
         model_clear(k);
      end else if (m_hold[k]) begin
         if (s_ordy) model_clear(k);
      end else if (s_valid) begin
`ifdef QMAC_SAT_EN
         bit h1, h2;
         m_se[k] = clampw(m_se[k] + s_e, aw, h1);
         m_sa[k] = clampw(m_sa[k] + s_a, aw, h2);
         m_sat[k] = m_sat[k] | h1 | h2;
`else
         m_se[k] = m_se[k] + s_e;
         m_sa[k] = m_sa[k] + s_a;
`endif
         m_cnt[k]++;
         if (m_cnt[k] == len_of(k)) begin
            m_cnt[k]  = 0;
            m_hold[k] = 1'b1;
            m_err[k]  = wrapw(wrapw(m_se[k], aw) - wrapw(m_sa[k], aw), aw);
         end
      end
   endtask

   // Per-cycle compare of every instance against the model.
   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         model_step(k);
         chk("in_ready", k, rdy[k], !m_hold[k]);
         chk("out_valid", k, vld[k], m_hold[k]);
         chk("out_sat", k, sat[k], m_sat[k]);
         chk("out_acc_exact", k, acc_e[k], wrapw(m_se[k], aw_of(k)));
         chk("out_acc_approx", k, acc_a[k], wrapw(m_sa[k], aw_of(k)));
         chk("out_err", k, err[k], m_err[k]);
      end
   end

   task automatic drive(input logic r, input logic v, input int e, input int a,
                        input logic ordy);
      @(posedge clk);
      #1;
      rst       = r;
      in_valid  = v;
      in_exact  = 16'(e);
      in_approx = 16'(a);
      out_ready = ordy;
   endtask

   initial begin
      // Reset held two cycles with a valid beat present.
      drive(1'b1, 1'b1, 55, 44, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk("rst_in_ready", 0, rdy[0], 1'b1);
      chk("rst_out_valid", 0, vld[0], 1'b0);
      chk("rst_acc_exact", 0, acc_e[0], 0);
      chk("rst_err", 0, err[0], 0);
      chk("rst_sat", 0, sat[0], 1'b0);

      // Four beats 100/96.
      repeat (4) drive(1'b0, 1'b1, 100, 96, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk("basic_valid", 0, vld[0], 1'b1);
      chk("basic_ready", 0, rdy[0], 1'b0);
      chk("basic_exact", 0, acc_e[0], 400);
      chk("basic_approx", 0, acc_a[0], 384);
      chk("basic_err", 0, err[0], 16);
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      drive(1'b0, 1'b0, 0, 0, 1'b0);

      // Gaps, then a held result under backpressure.
      drive(1'b0, 1'b1, 16384, 16380, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 1'b1, -200, -190, 1'b0);
      drive(1'b0, 1'b1, 5, 0, 1'b0);
      drive(1'b0, 1'b1, 0, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 0, 0, 1'b0);
         @(negedge clk);
         chk("stall_exact", 0, acc_e[0], 16189);
         chk("stall_approx", 0, acc_a[0], 16190);
         chk("stall_err", 0, err[0], -1);
      end
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      drive(1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk("clear_ready", 0, rdy[0], 1'b1);
      chk("clear_exact", 0, acc_e[0], 0);

      // Reset mid dot product.
      repeat (2) drive(1'b0, 1'b1, 1000, 1000, 1'b0);
      drive(1'b1, 1'b0, 0, 0, 1'b0);
      repeat (4) drive(1'b0, 1'b1, 1, 1, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk("midrst_exact", 0, acc_e[0], 4);

      // Saturation / wrap on the 17-bit instance.
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      repeat (4) drive(1'b0, 1'b1, 32767, 0, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk("sat_valid", 1, vld[1], 1'b1);
`ifdef QMAC_SAT_EN
      chk("sat_exact", 1, acc_e[1], 65535);
      chk("sat_flag", 1, sat[1], 1'b1);
      chk("sat_err", 1, err[1], 65535);
`else
      chk("wrap_exact", 1, acc_e[1], -4);
      chk("wrap_flag", 1, sat[1], 1'b0);
`endif

      // LEN=1 instance with out_ready held high.
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      drive(1'b0, 1'b1, 7, 7, 1'b1);
      drive(1'b0, 1'b1, 9, 9, 1'b1);
      @(negedge clk);
      chk("len1_first_valid", 2, vld[2], 1'b1);
      chk("len1_first_exact", 2, acc_e[2], 7);
      drive(1'b0, 1'b1, 9, 9, 1'b1);
      @(negedge clk);
      chk("len1_bubble_valid", 2, vld[2], 1'b0);
      chk("len1_bubble_ready", 2, rdy[2], 1'b1);
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      @(negedge clk);
      chk("len1_second_valid", 2, vld[2], 1'b1);
      chk("len1_second_exact", 2, acc_e[2], 9);
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      @(negedge clk);
      chk("len1_after_valid", 2, vld[2], 1'b0);

      // Randomized traffic; extremes are frequent to exercise clamp/wrap at ACC_W=17.
      for (int i = 0; i < 3000; i++) begin
         int e, a;
         if ($urandom_range(0, 3) == 0) begin
            e = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
            a = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
         end else begin
            e = int'($urandom_range(0, 65535)) - 32768;
            a = int'($urandom_range(0, 65535)) - 32768;
         end
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, e, a,
               $urandom_range(0, 1) == 1);
      end
      drive(1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
